// File: rtl/truth_sweep_ctrl.sv
// Drives {a,b,c,d} through all 16 vectors, samples N_IMPL implementation outputs after SETTLE cycles,
// records the truth table of f_in[0] and counts disagreeing vectors. SWEEP_STOP_ON_FAIL_EN: stop at first mismatch.
module truth_sweep_ctrl #(
    parameter int N_IMPL = 3,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_IMPL-1:0] f_in,
    output logic [3:0]        abcd,
    output logic              busy,
    output logic              done,
    output logic              match,
    output logic [4:0]        mism_cnt,
    output logic [3:0]        first_bad,
    output logic [15:0]       truth
);
    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, FIN} state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [3:0]  abcd_q, abcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  mism_q, mism_d;
    logic [3:0]  first_q, first_d;
    logic [15:0] truth_q, truth_d;
    logic        match_q, match_d;
    logic        vec_bad;
    logic        stop_now;

    // Implementations agree only when every output is the same value.
    assign vec_bad = (|f_in) && !(&f_in);

`ifdef SWEEP_STOP_ON_FAIL_EN
    assign stop_now = (abcd_q == 4'hF) || vec_bad;
`else
    assign stop_now = (abcd_q == 4'hF);
`endif

    always_comb begin
        state_d = state_q;
        abcd_d  = abcd_q;
        cnt_d   = cnt_q;
        mism_d  = mism_q;
        first_d = first_q;
        truth_d = truth_q;
        match_d = match_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = APPLY;
                    abcd_d  = 4'h0;
                    cnt_d   = SETTLE_LD;
                    mism_d  = 5'd0;
                    first_d = 4'h0;
                    truth_d = 16'h0000;
                    match_d = 1'b0;
                end
            end
            APPLY: begin
                if (cnt_q == 4'd0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SAMPLE: begin
                truth_d[abcd_q] = f_in[0];
                if (vec_bad) begin
                    if (mism_q == 5'd0) begin
                        first_d = abcd_q;
                    end
                    mism_d = mism_q + 5'd1;
                end
                if (stop_now) begin
                    state_d = FIN;
                end else begin
                    abcd_d  = abcd_q + 4'd1;
                    cnt_d   = SETTLE_LD;
                    state_d = APPLY;
                end
            end
            FIN: begin
                match_d = (mism_q == 5'd0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            abcd_q  <= 4'h0;
            cnt_q   <= 4'd0;
            mism_q  <= 5'd0;
            first_q <= 4'h0;
            truth_q <= 16'h0000;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            abcd_q  <= abcd_d;
            cnt_q   <= cnt_d;
            mism_q  <= mism_d;
            first_q <= first_d;
            truth_q <= truth_d;
            match_q <= match_d;
        end
    end

    assign abcd      = abcd_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign match     = match_q;
    assign mism_cnt  = mism_q;
    assign first_bad = first_q;
    assign truth     = truth_q;
endmodule

// File: doc/truth_sweep_ctrl.md
# truth_sweep_ctrl

Sequencer that drives the shared 4-bit input bus `{a,b,c,d}` of the boolean-function implementations (SoP, minimized, NAND/NOR forms) through all 16 vectors. It waits a programmable settle time, then samples every implementation's output and checks that they agree. It captures the 16-entry truth table of implementation 0, counts disagreeing vectors and reports the first failing index. It replaces the hand-written `#1` sweep loops in benches and serves as an on-chip equivalence checker.

## Interface
Parameters:
- `N_IMPL`, 3: number of implementation outputs compared; legal range 2..8.
- `SETTLE`, 1: cycles each vector is held before sampling; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  launch a sweep; sampled only in IDLE.
- `f_in`  in  N_IMPL  outputs of the implementations; bit 0 is the truth-table source.
- `abcd`  out  4  vector driven to all implementations; `abcd[3]` = a.
- `busy`  out  1  high from start acceptance until the FIN cycle inclusive.
- `done`  out  1  one-cycle pulse in FIN.
- `match`  out  1  1 = last completed sweep had zero mismatches.
- `mism_cnt`  out  5  count of mismatching vectors in the current/last sweep (0..16).
- `first_bad`  out  4  index of the first mismatching vector; meaningful only when `mism_cnt != 0`.
- `truth`  out  16  bit i = `f_in[0]` sampled at vector i.

## Operation
- States: IDLE, APPLY, SAMPLE, FIN.
- Reset values: state IDLE; `abcd=0`, `busy=0`, `done=0`, `match=0`, `mism_cnt=0`, `first_bad=0`, `truth=16'h0000`; settle counter 0.
- IDLE, `start=1`: go to APPLY; `abcd=0`; clear `mism_cnt`, `first_bad`, `truth` and `match`; `busy=1`.
- APPLY: hold `abcd` for SETTLE cycles (down-counter), then go to SAMPLE.
- SAMPLE: the vector mismatches when `f_in` is neither all-0 nor all-1.
  - Write `truth[abcd] <= f_in[0]`.
  - On mismatch: if `mism_cnt == 0`, set `first_bad <= abcd`; increment `mism_cnt`.
  - If `abcd == 4'hF` (or early stop, see Configuration): go to FIN.
  - Otherwise: `abcd <= abcd + 1`, go to APPLY.
- FIN: `done=1`, `busy=1`, `match <= (mism_cnt == 0)`; `abcd` holds its last value. Next state is IDLE.
- `start` outside IDLE is ignored. `start` held high relaunches a sweep in the first IDLE cycle after FIN.
- `mism_cnt` is 5 bits and saturation is impossible (max 16). `abcd` never wraps within a sweep.
- `truth`, `mism_cnt`, `first_bad` and `match` hold until the next accepted start or reset.

## Timing
- Start accepted at edge k: APPLY from edge k. Each vector takes SETTLE+1 cycles.
- FIN is entered at edge k + 16·(SETTLE+1). With SETTLE=1, `done` is high in the cycle starting at edge k+32.
- `f_in` is sampled combinationally in SAMPLE; the implementations must settle within SETTLE cycles of an `abcd` change.
- Reset mid-sweep forces all reset values immediately; the sweep is lost and `done` is not pulsed.
- Minimum start-to-start period is 16·(SETTLE+1)+2 cycles.

## Configuration
- `SWEEP_STOP_ON_FAIL_EN` defined: SAMPLE with a mismatch goes directly to FIN. `mism_cnt` ends at 1, and `truth` bits above `first_bad` remain 0.
- Not defined: the full 16-vector sweep always runs; `mism_cnt` counts all failing vectors.

## Test plan
- All three `f_in` driven by a model of minterms {1,3,4,5,7,A,B,D,F}, SETTLE=1, start pulse -> `done` at k+32, `truth=16'hACBA`, `mism_cnt=0`, `match=1`, `busy` low the cycle after `done`.
- Same stimulus, `f_in[2]` inverted at vector 6 only -> `mism_cnt=1`, `first_bad=6`, `match=0`, `truth=16'hACBA`.
- Faults at vectors 2 and 9, macro undefined -> `mism_cnt=2`, `first_bad=2`, `done` at k+32. Macro defined -> `mism_cnt=1`, `first_bad=2`, `done` at k+6, `truth=16'h0002`.
- `rst` asserted while `abcd=5` -> outputs at reset values asynchronously, no `done`. A new start after release gives a clean full sweep.
- `start` pulsed while busy -> ignored, single `done`. `start` held high -> back-to-back sweeps with `done` every 34 cycles (SETTLE=1).
- SETTLE=4 with clean model -> `abcd` steps every 5 cycles; `done` at k+80.
